// File: rtl/completion_rob.sv
// Reorder buffer that allocates up to 3 entries per cycle and tracks out-of-order completion.
// It retires up to RETIRE_W consecutive completed entries from the head each cycle, in program order.
module completion_rob #(
  parameter int DEPTH    = 32,
  parameter int RETIRE_W = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               alloc_valid,
  input  logic [23:0]              alloc_arch_dest,
  input  logic [29:0]              alloc_phys_dest,
  output logic                     alloc_ready,
  output logic [14:0]              alloc_idx,
  input  logic [2:0]               cmplt_valid,
  input  logic [14:0]              cmplt_rob,
  output logic [RETIRE_W-1:0]      retire_valid,
  output logic [RETIRE_W*8-1:0]    retire_arch,
  output logic [RETIRE_W*10-1:0]   retire_phys,
  output logic [5:0]               occupancy
);

  localparam int IDX_W = 5;
  localparam int CNT_W = $clog2(RETIRE_W + 1);

  logic [IDX_W-1:0]         head_q, tail_q, head_d, tail_d;
  logic [DEPTH-1:0]         valid_q, done_q, valid_d, done_d;
  logic [7:0]               arch_q [DEPTH];
  logic [9:0]               phys_q [DEPTH];
  logic [5:0]               occ_d;

  logic [1:0]               alloc_cnt;
  logic                     alloc_fire;
  logic [IDX_W-1:0]         cidx;
  logic [IDX_W-1:0]         aidx;

  logic [RETIRE_W-1:0]      ret_mask;
  logic [CNT_W-1:0]         ret_n;
  logic                     ret_stop;
  logic [IDX_W-1:0]         ridx;
  logic [RETIRE_W*8-1:0]    ret_arch_d;
  logic [RETIRE_W*10-1:0]   ret_phys_d;

  // Allocation is all-or-nothing: either every requesting slot lands, or none does.
  assign alloc_ready = (occupancy <= 6'(DEPTH - 3));
  assign alloc_fire  = alloc_ready && (|alloc_valid);

  always_comb begin
    alloc_cnt = '0;
    alloc_idx = '0;
    for (int k = 0; k < 3; k++) begin
      alloc_idx[k*5 +: 5] = tail_q + IDX_W'(alloc_cnt);
      if (alloc_valid[k]) alloc_cnt = alloc_cnt + 2'd1;
    end
  end

  // Retirement looks only at pre-edge state, so a completion at this edge waits a cycle.
  always_comb begin
    ret_mask   = '0;
    ret_n      = '0;
    ret_stop   = 1'b0;
    ridx       = '0;
    ret_arch_d = '0;
    ret_phys_d = '0;
    for (int i = 0; i < RETIRE_W; i++) begin
      ridx = head_q + IDX_W'(i);
      if (!ret_stop && valid_q[ridx] && done_q[ridx]) begin
        ret_mask[i]            = 1'b1;
        ret_n                  = ret_n + CNT_W'(1);
        ret_arch_d[i*8 +: 8]   = arch_q[ridx];
        ret_phys_d[i*10 +: 10] = phys_q[ridx];
      end else begin
        ret_stop = 1'b1;
      end
    end
  end

  // Order matters: completion, then retire clear, then allocation so allocation wins on a shared index.
  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    cidx    = '0;
    aidx    = '0;
    for (int p = 0; p < 3; p++) begin
      cidx = cmplt_rob[p*5 +: 5];
      if (cmplt_valid[p] && valid_q[cidx]) done_d[cidx] = 1'b1;
    end
    for (int i = 0; i < RETIRE_W; i++) begin
      ridx_clear(i);
    end
    if (alloc_fire) begin
      for (int k = 0; k < 3; k++) begin
        aidx = alloc_idx[k*5 +: 5];
        if (alloc_valid[k]) begin
          valid_d[aidx] = 1'b1;
          done_d[aidx]  = 1'b0;
        end
      end
    end
  end

  function automatic void ridx_clear(input int i);
    logic [IDX_W-1:0] idx;
    idx = head_q + IDX_W'(i);
    if (ret_mask[i]) begin
      valid_d[idx] = 1'b0;
      done_d[idx]  = 1'b0;
    end
  endfunction

  assign head_d = head_q + IDX_W'(ret_n);
  assign tail_d = alloc_fire ? (tail_q + IDX_W'(alloc_cnt)) : tail_q;
  assign occ_d  = occupancy + (alloc_fire ? 6'(alloc_cnt) : 6'd0) - 6'(ret_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      occupancy    <= '0;
      valid_q      <= '0;
      done_q       <= '0;
      retire_valid <= '0;
      retire_arch  <= '0;
      retire_phys  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      occupancy    <= occ_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
      retire_valid <= ret_mask;
      retire_arch  <= ret_arch_d;
      retire_phys  <= ret_phys_d;
    end
  end

  // Payload needs no reset; the valid bits decide whether it means anything.
  always_ff @(posedge clk) begin
    if (alloc_fire && !rst) begin
      for (int k = 0; k < 3; k++) begin
        if (alloc_valid[k]) begin
          arch_q[alloc_idx[k*5 +: 5]] <= alloc_arch_dest[k*8 +: 8];
          phys_q[alloc_idx[k*5 +: 5]] <= alloc_phys_dest[k*10 +: 10];
        end
      end
    end
  end

endmodule

// File: tb/tb_completion_rob.sv
// Bench for completion_rob: an in-order queue model predicts retirements into a scoreboard,
// and a negedge monitor checks every retire group and the occupancy against it.
module tb_completion_rob;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  alloc_valid = '0;
  logic [23:0] alloc_arch_dest = '0;
  logic [29:0] alloc_phys_dest = '0;
  logic        alloc_ready;
  logic [14:0] alloc_idx;
  logic [2:0]  cmplt_valid = '0;
  logic [14:0] cmplt_rob = '0;
  logic [2:0]  retire_valid;
  logic [23:0] retire_arch;
  logic [29:0] retire_phys;
  logic [5:0]  occupancy;

  completion_rob #(.DEPTH(32), .RETIRE_W(3)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_arch_dest(alloc_arch_dest), .alloc_phys_dest(alloc_phys_dest),
    .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmplt_valid(cmplt_valid), .cmplt_rob(cmplt_rob),
    .retire_valid(retire_valid), .retire_arch(retire_arch), .retire_phys(retire_phys),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] idx;
    logic [7:0] arch;
    logic [9:0] phys;
    bit         done;
  } ent_t;

  typedef struct {
    int          tag;
    logic [2:0]  v;
    logic [23:0] a;
    logic [29:0] p;
  } exp_t;

  ent_t rob[$];
  exp_t sbq[$];
  int   model_tail = 0;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Monitor: pops one expected retire group whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      chk("occupancy", 32'(occupancy), 32'(rob.size()));
      if (retire_valid != 3'b000) begin
        if (sbq.size() == 0) begin
          chk("spurious_retire", 32'(retire_valid), 32'd0);
        end else begin
          x = sbq.pop_front();
          chk("retire_edge", 32'(edge_n), 32'(x.tag));
          chk("retire_valid", 32'(retire_valid), 32'(x.v));
          chk("retire_arch", 32'(retire_arch), 32'(x.a));
          chk("retire_phys", 32'(retire_phys), 32'(x.p));
        end
      end else begin
        chk("idle_retire_data", 32'(|{retire_arch, retire_phys}), 32'd0);
        if (sbq.size() > 0 && sbq[0].tag <= edge_n) begin
          x = sbq.pop_front();
          chk("missed_retire", 32'(retire_valid), 32'(x.v));
        end
      end
    end
  end

  // One clock of stimulus; model applies pre-edge retire, completions, then allocation.
  task automatic step(input logic [2:0] av, input logic [23:0] aa, input logic [29:0] ap,
                      input logic [2:0] cv, input logic [14:0] cr);
    int   rank;
    int   n;
    bit   ready;
    bit   stop;
    exp_t x;
    ent_t e;
    alloc_valid = av; alloc_arch_dest = aa; alloc_phys_dest = ap;
    cmplt_valid = cv; cmplt_rob = cr;
    #2;
    ready = (rob.size() <= 29);
    chk("alloc_ready", 32'(alloc_ready), 32'(ready));
    rank = 0;
    for (int k = 0; k < 3; k++) begin
      if (av[k]) begin
        chk("alloc_idx", 32'(alloc_idx[5*k +: 5]), 32'((model_tail + rank) % 32));
        rank++;
      end
    end
    @(posedge clk);
    edge_n++;
    n = 0; stop = 0;
    for (int i = 0; i < 3; i++) begin
      if (!stop && i < rob.size() && rob[i].done) n++;
      else stop = 1;
    end
    for (int p = 0; p < 3; p++) begin
      if (cv[p]) begin
        for (int j = 0; j < rob.size(); j++) begin
          if (rob[j].idx == cr[5*p +: 5]) begin
            e = rob[j]; e.done = 1; rob[j] = e;
          end
        end
      end
    end
    if (n > 0) begin
      x.tag = edge_n; x.v = '0; x.a = '0; x.p = '0;
      for (int i = 0; i < n; i++) begin
        x.v[i] = 1'b1;
        x.a[8*i +: 8] = rob[0].arch;
        x.p[10*i +: 10] = rob[0].phys;
        void'(rob.pop_front());
      end
      sbq.push_back(x);
    end
    if (ready && av != 3'b000) begin
      for (int k = 0; k < 3; k++) begin
        if (av[k]) begin
          e.idx = 5'(model_tail); e.arch = aa[8*k +: 8]; e.phys = ap[10*k +: 10]; e.done = 0;
          rob.push_back(e);
          model_tail = (model_tail + 1) % 32;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(3'b000, '0, '0, 3'b000, '0);
  endtask

  task automatic front_cmplt(input int maxn, output logic [2:0] cv, output logic [14:0] cr);
    int c;
    cv = '0; cr = '0; c = 0;
    for (int j = 0; j < rob.size(); j++) begin
      if (!rob[j].done && c < maxn) begin
        cr[5*c +: 5] = rob[j].idx;
        cv[c] = 1'b1;
        c++;
      end
    end
  endtask

  task automatic drain();
    int guard;
    logic [2:0]  cv;
    logic [14:0] cr;
    guard = 0;
    while (rob.size() > 0 && guard < 100) begin
      front_cmplt(3, cv, cr);
      step(3'b000, '0, '0, cv, cr);
      guard++;
    end
    idle(1);
    if (rob.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: occupancy %0d expected 0", rob.size());
    end
  endtask

  task automatic move_to(input int target);
    int guard;
    logic [2:0]  cv;
    logic [14:0] cr;
    guard = 0;
    while (model_tail != target && guard < 64) begin
      front_cmplt(1, cv, cr);
      step(3'b001, 24'($urandom), 30'($urandom), cv, cr);
      guard++;
    end
    chk("move_to_tail", 32'(model_tail), 32'(target));
    drain();
  endtask

  initial begin
    logic [2:0]  cv;
    logic [14:0] cr;
    repeat (2) begin
      @(posedge clk);
      edge_n++;
    end
    #1 rst = 1'b0;
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_retire_valid", 32'(retire_valid), 32'd0);
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);

    // Three allocations into an empty ROB
    step(3'b111, {8'h65, 8'h43, 8'h21}, 30'($urandom), 3'b000, '0);
    chk("alloc3_occupancy", 32'(occupancy), 32'd3);

    // Out-of-order completion: idx 1 first must not retire
    step(3'b000, '0, '0, 3'b100, {5'd1, 10'd0});
    idle(1);
    step(3'b000, '0, '0, 3'b010, 15'd0);
    chk("no_early_retire", 32'(retire_valid), 32'd0);
    idle(1);
    chk("ooo_retire_valid", 32'(retire_valid), 32'b011);
    chk("ooo_retire_arch", 32'(retire_arch[15:0]), 32'h4321);
    drain();

    // Fill to 30, then a further request must be ignored
    for (int i = 0; i < 10; i++) step(3'b111, 24'($urandom), 30'($urandom), 3'b000, '0);
    chk("fill_occupancy", 32'(occupancy), 32'd30);
    chk("fill_ready_low", 32'(alloc_ready), 32'd0);
    step(3'b111, 24'($urandom), 30'($urandom), 3'b000, '0);
    chk("full_ignored", 32'(occupancy), 32'd30);
    drain();

    // Wrap from 30 through 31 to 0
    move_to(30);
    step(3'b111, {8'hC3, 8'hB2, 8'hA1}, 30'($urandom), 3'b000, '0);
    step(3'b000, '0, '0, 3'b111, {5'd0, 5'd31, 5'd30});
    idle(1);
    chk("wrap_retire_valid", 32'(retire_valid), 32'b111);
    chk("wrap_retire_arch", 32'(retire_arch), 32'hC3B2A1);
    chk("wrap_next_idx", 32'(alloc_idx[4:0]), 32'd1);

    // Same-edge completion and allocation of index 5
    move_to(5);
    step(3'b001, 24'h77, 30'($urandom), 3'b001, 15'd5);
    idle(4);
    chk("same_edge_held", 32'(occupancy), 32'd1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1 && rob.size() > 0) begin
        front_cmplt(3, cv, cr);
        if ($urandom_range(0, 1) == 1) cr[4:0] = rob[$urandom_range(0, rob.size() - 1)].idx;
        cv = cv & 3'($urandom);
      end else begin
        cv = 3'($urandom); cr = 15'($urandom);
      end
      step(3'($urandom), 24'($urandom), 30'($urandom), cv, cr);
    end
    drain();

    // Asynchronous reset mid-cycle with 12 entries in flight
    for (int i = 0; i < 4; i++) step(3'b111, 24'($urandom), 30'($urandom), 3'b000, '0);
    chk("pre_reset_occupancy", 32'(occupancy), 32'd12);
    #3 rst = 1'b1;
    alloc_valid = '0; cmplt_valid = '0;
    #1;
    chk("async_occupancy", 32'(occupancy), 32'd0);
    chk("async_retire_valid", 32'(retire_valid), 32'd0);
    chk("async_retire_data", 32'(|{retire_arch, retire_phys}), 32'd0);
    rob.delete(); sbq.delete(); model_tail = 0;
    @(posedge clk);
    edge_n++;
    #1 rst = 1'b0;
    #1;
    chk("post_reset_ready", 32'(alloc_ready), 32'd1);
    chk("post_reset_idx0", 32'(alloc_idx[4:0]), 32'd0);
    step(3'b011, 24'($urandom), 30'($urandom), 3'b000, '0);
    drain();
    idle(2);
    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/completion_rob.md
COMPLETION_ROB -- requirements
Module: completion_rob

Interface
REQ-001 SHALL have parameter DEPTH, default 32, ROB entry count; the index width is fixed at 5 bits, so DEPTH is 32.
REQ-002 SHALL have parameter RETIRE_W, default 3, maximum retirements per cycle.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port alloc_valid  input  3  per-slot allocation request; bit k is slot k.
REQ-006 SHALL have port alloc_arch_dest  input  24  per slot 8 bits: [3:0] arch dest reg, [7:4] arch flag reg.
REQ-007 SHALL have port alloc_phys_dest  input  30  per slot 10 bits: [4:0] phys dest reg, [9:5] phys flag reg.
REQ-008 SHALL have port alloc_ready  output  1  high when at least 3 entries are free.
REQ-009 SHALL have port alloc_idx  output  15  ROB index assigned to each slot, 5 bits per slot.
REQ-010 SHALL have port cmplt_valid  input  3  completion strobes: bit2 arithmetic, bit1 memory, bit0 terminate.
REQ-011 SHALL have port cmplt_rob  input  15  completing ROB index per port, 5 bits each, in the same bit order as cmplt_valid.
REQ-012 SHALL have port retire_valid  output  3  registered; retire slot k is valid; set bits are contiguous from bit 0.
REQ-013 SHALL have port retire_arch  output  24  registered; arch dest and flag regs of each retiring entry.
REQ-014 SHALL have port retire_phys  output  30  registered; phys dest and flag regs of each retiring entry.
REQ-015 SHALL have port occupancy  output  6  registered; number of valid entries, 0..32.

Function
REQ-016 SHALL hold, per entry: a valid bit, a done bit, an 8-bit arch field and a 10-bit phys field; head and tail are 5-bit pointers that wrap modulo 32.
REQ-017 SHALL drive alloc_ready combinationally as (occupancy <= DEPTH-3), using the pre-edge occupancy.
REQ-018 SHALL compute alloc_idx[k] combinationally as tail plus the number of set alloc_valid bits below k, modulo 32; alloc_idx is don't-care for unset slots.
REQ-019 SHALL, when alloc_ready and alloc_valid are both nonzero at an edge: write each requesting slot to its alloc_idx; set valid=1 and done=0; advance tail by popcount(alloc_valid).
REQ-020 SHALL ignore alloc_valid entirely when alloc_ready is 0: no state change and no partial allocation.
REQ-021 SHALL, on each cmplt_valid bit, set done on entry cmplt_rob at the edge, but only if that entry is valid.
REQ-022 SHALL ignore a completion to an invalid entry; duplicate completions SHALL be harmless.
REQ-023 SHALL give allocation precedence when a completion and an allocation target the same index at one edge: the entry ends with done=0.
REQ-024 SHALL evaluate retirement from pre-edge state: retire n = number of consecutive valid and done entries starting at head, capped at RETIRE_W.
REQ-025 SHALL, at the edge, register retire outputs for those n entries (slot 0 = head); clear their valid and done bits; advance head by n.
REQ-026 SHALL give latency: completion at edge E gives retire_valid after edge E+1 at the earliest, which is 1 cycle of done-to-retire latency.
REQ-027 SHALL never retire an entry completed at the current edge in that same cycle.
REQ-028 SHALL update occupancy at each edge as occupancy + allocated - retired; simultaneous allocation and retirement are both honoured.
REQ-029 SHALL stop retirement at the first entry that is not done; a done entry behind it SHALL wait.
REQ-030 SHALL drive retire_arch and retire_phys to 0 in slots whose retire_valid bit is low.
REQ-031 SHALL handle wrap-around: allocation and retirement across index 31 to 0 behave identically to the non-wrapping case.
REQ-032 SHALL, at empty (occupancy 0), retire nothing; at full (occupancy 32), hold alloc_ready low and still accept completions.

Reset
REQ-033 SHALL, on rst high, immediately and asynchronously set head, tail and occupancy to 0, clear all valid and done bits, and clear retire_valid, retire_arch and retire_phys to 0.
REQ-034 SHALL treat reset mid-operation as discarding all in-flight entries; after release, alloc_ready=1 and alloc_idx slot 0 = 0.
REQ-035 SHALL accept no allocation and no completion while rst is high.

Verification
REQ-036 SHALL cover: allocate 3 entries with arch 0x21,0x43,0x65 into empty ROB -> alloc_idx 0,1,2; after edge occupancy=3; no retire.
REQ-037 SHALL cover: complete idx 1 then idx 0 -> nothing retires after idx 1 completes; after idx 0 completes, next cycle retire_valid=3'b011 with arch 0x21,0x43.
REQ-038 SHALL cover: fill with 30 allocations -> alloc_ready=0 at occupancy 30; the next alloc_valid=3'b111 is ignored and occupancy stays 30.
REQ-039 SHALL cover: head=tail=30, allocate 3 -> alloc_idx 30,31,0; complete all three -> retire slots hold idx 30,31,0 in order; head=1.
REQ-040 SHALL cover: same-edge completion of idx 5 and allocation of idx 5 (after wrap) -> entry 5 done=0 and it is not retired.
REQ-041 SHALL cover: rst asserted asynchronously mid-cycle with occupancy 12 -> outputs zero before the next clock edge; after release occupancy=0 and alloc_ready=1.
